// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared SHA-256 definitions for the round sequencer slice:
//   - K[0..63]  round constants (reference table; the sequencer reads its
//               constants through sha256_k_rom)
//   - H0[0..7]  initial hash value (IV), word 0 = a
//   - state_t   sequencer FSM states
package sha256_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom
//   Combinational SHA-256 round-constant lookup.
//   Ports:
//     idx  in   6   round index t
//     k    out  32  K[t]
module sha256_k_rom (
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  always_comb begin
    k = 32'h0;
    case (idx)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
  end

endmodule

// File: rtl/sha256_round_sequencer.sv
// sha256_round_sequencer
//   Drives an external registered SHA-256 round unit (one round per clock)
//   through all rounds of a 512-bit block, then adds the chaining value to
//   the final working state and offers the digest on a valid/ready handshake.
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     abort                   synchronous flush back to IDLE
//     in_valid/in_ready       block + chaining value handshake
//     in_block [511:0]        M0..M15, M0 in [511:480]
//     in_h     [255:0]        chaining value {a..h}, a in [255:224]
//     rnd_w/rnd_state         round unit inputs (W-window, {a..h})
//     rnd_k                   K[t] for the current round
//     rnd_t1_tmp2/3           W[t]+K[t]+h and that plus d
//     rnd_w_next/state_next   round unit registered outputs
//     out_valid/out_ready     digest handshake
//     digest   [255:0]        H + final state, word 0 in [255:224]
//     busy                    sequencer not idle
module sha256_round_sequencer
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [255:0] in_h,
  output logic [511:0] rnd_w,
  output logic [255:0] rnd_state,
  output logic [31:0]  rnd_k,
  output logic [31:0]  rnd_t1_tmp2,
  output logic [31:0]  rnd_t1_tmp3,
  input  logic [511:0] rnd_w_next,
  input  logic [255:0] rnd_state_next,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [511:0]       blk_q, blk_d;
  logic [255:0]       h_q, h_d;
  logic [255:0]       digest_q, digest_d;
  logic [255:0]       sum_words;
  logic [5:0]         k_idx;

  assign k_idx = 6'(idx_q);

  sha256_k_rom u_k_rom (
    .idx (k_idx),
    .k   (rnd_k)
  );

  // Round 0 takes the latched block/H; every later round closes the loop
  // through the round unit's own registers, so no W/state copy lives here.
  assign rnd_w     = (idx_q == '0) ? blk_q : rnd_w_next;
  assign rnd_state = (idx_q == '0) ? h_q   : rnd_state_next;

  // Partial T1 sums taken off the critical path of the round unit:
  // w_t is the oldest window word, h is word 7 and d is word 3 of the state.
  assign rnd_t1_tmp2 = rnd_w[511:480] + rnd_k + rnd_state[31:0];
  assign rnd_t1_tmp3 = rnd_t1_tmp2 + rnd_state[159:128];

  // Per-word feed-forward addition; each word wraps independently.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ffwd
    assign sum_words[gi*32 +: 32] = h_q[gi*32 +: 32] + rnd_state_next[gi*32 +: 32];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    blk_d    = blk_q;
    h_d      = h_q;
    digest_d = digest_q;

    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            blk_d   = in_block;
            h_d     = in_h;
            idx_d   = '0;
            state_d = ROUND;
          end
        end
        ROUND: begin
          if (idx_q == IDX_W'(ROUNDS - 1)) begin
            idx_d   = '0;
            state_d = FINAL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        FINAL: begin
          digest_d = sum_words;
          state_d  = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      blk_q    <= '0;
      h_q      <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      blk_q    <= blk_d;
      h_q      <= h_d;
      digest_q <= digest_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign digest    = digest_q;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// tb_sha256_round_sequencer
//   Pairs the sequencer with a behavioural registered round unit and checks
//   digests against known answers and a plain-arithmetic SHA-256 compression.
module tb_sha256_round_sequencer;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_block = '0;
  logic [255:0] in_h = '0;
  logic [511:0] rnd_w;
  logic [255:0] rnd_state;
  logic [31:0]  rnd_k;
  logic [31:0]  rnd_t1_tmp2;
  logic [31:0]  rnd_t1_tmp3;
  logic [511:0] rnd_w_next = '0;
  logic [255:0] rnd_state_next = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] digest;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [255:0] iv_vec;
  logic [511:0] abc_blk;
  logic [511:0] empty_blk;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  always #5 clk = ~clk;

  sha256_round_sequencer #(.ROUNDS(64), .IDX_W(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .abort          (abort),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_block       (in_block),
    .in_h           (in_h),
    .rnd_w          (rnd_w),
    .rnd_state      (rnd_state),
    .rnd_k          (rnd_k),
    .rnd_t1_tmp2    (rnd_t1_tmp2),
    .rnd_t1_tmp3    (rnd_t1_tmp3),
    .rnd_w_next     (rnd_w_next),
    .rnd_state_next (rnd_state_next),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .digest         (digest),
    .busy           (busy)
  );

  // ---------------- SHA-256 helper functions ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Full compression of one block with message schedule, working variables
  // and feed-forward, straight from the SHA-256 definition.
  function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + bsig1(v[4]) + ch(v[4], v[5], v[6]) + K[t] + w[t];
      t2 = bsig0(v[0]) + maj(v[0], v[1], v[2]);
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rand_h();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  // ---------------- Behavioural registered round unit ----------------
  // Consumes the sequencer's precomputed T1 partials, so a wrong partial sum
  // shows up in the digest.
  function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] tmp2, input logic [31:0] tmp3);
    logic [31:0] a, b, c, e, f, g, x;
    a = s[255:224]; b = s[223:192]; c = s[191:160];
    e = s[127:96];  f = s[95:64];   g = s[63:32];
    x = bsig1(e) + ch(e, f, g);
    return {tmp2 + x + bsig0(a) + maj(a, b, c), a, b, c, tmp3 + x, e, f, g};
  endfunction

  function automatic logic [511:0] sched_fn(input logic [511:0] w);
    logic [31:0] nw;
    nw = ssig1(w[63:32]) + w[223:192] + ssig0(w[479:448]) + w[511:480];
    return {w[479:0], nw};
  endfunction

  always @(posedge clk) begin
    rnd_state_next <= round_fn(rnd_state, rnd_t1_tmp2, rnd_t1_tmp3);
    rnd_w_next     <= sched_fn(rnd_w);
  end

  // ---------------- Scenario tasks ----------------
  task automatic run_block(input string name, input logic [511:0] blk, input logic [255:0] hin,
                           input logic [255:0] exp_dig);
    int n;
    @(negedge clk);
    in_block = blk; in_h = hin; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 65) begin
      errors++; $display("FAIL %s_latency: got %0d expected 65", name, n);
    end
    checks++;
    if (digest !== exp_dig) begin
      errors++; $display("FAIL %s_digest: got %h expected %h", name, digest, exp_dig);
    end
    $display("block %s: latency=%0d digest=%h", name, n, digest);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || digest !== '0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b digest=%h expected 1 0 0 0",
               in_ready, out_valid, busy, digest);
    end
    reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_known_answers();
    run_block("abc", abc_blk, iv_vec, ABC_DIGEST);
    run_block("empty", empty_blk, iv_vec, EMPTY_DIGEST);
  endtask

  task automatic test_random();
    logic [511:0] b;
    logic [255:0] h;
    for (int i = 0; i < 4; i++) begin
      b = rand_block();
      h = rand_h();
      run_block($sformatf("rand%0d", i), b, h, ref_compress(b, h));
    end
  endtask

  task automatic test_stall();
    logic [511:0] b;
    logic [255:0] held, exp_d;
    int n;
    b = rand_block();
    exp_d = ref_compress(b, iv_vec);
    @(negedge clk);
    in_block = b; in_h = iv_vec; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    held = digest;
    checks++;
    if (held !== exp_d) begin
      errors++; $display("FAIL stall_digest: got %h expected %h", held, exp_d);
    end
    // Offer another block while the digest is not taken.
    in_block = rand_block(); in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (digest !== exp_d || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got digest=%h out_valid=%b in_ready=%b expected %h 1 0",
                 i, digest, out_valid, in_ready, exp_d);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
               in_ready, out_valid, busy);
    end
    $display("stall block: digest=%h held 20 clk", held);
  endtask

  task automatic test_back_to_back();
    logic [511:0] ba, bb;
    logic [255:0] ha, hb;
    logic [255:0] dig [2];
    int acc_cyc [2];
    int n_acc, n_dig, cyc;
    ba = rand_block(); bb = rand_block();
    ha = rand_h();     hb = iv_vec;
    n_acc = 0; n_dig = 0; cyc = 0;
    dig[0] = '0; dig[1] = '0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    while ((n_acc < 2 || n_dig < 2) && cyc < 400) begin
      // Inputs for the coming edge follow the number of accepts so far.
      in_block = (n_acc == 0) ? ba : bb;
      in_h     = (n_acc == 0) ? ha : hb;
      if (n_acc >= 2) in_valid = 1'b0;
      if (out_valid && n_dig < 2) begin
        dig[n_dig] = digest;
        n_dig++;
      end
      if (in_ready && in_valid && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_acc !== 2 || n_dig !== 2) begin
      errors++; $display("FAIL b2b_timeout: got accepts=%0d digests=%0d expected 2 2", n_acc, n_dig);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 67) begin
      errors++; $display("FAIL b2b_spacing: got %0d expected 67", acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (dig[0] !== ref_compress(ba, ha)) begin
      errors++; $display("FAIL b2b_digest0: got %h expected %h", dig[0], ref_compress(ba, ha));
    end
    checks++;
    if (dig[1] !== ref_compress(bb, hb)) begin
      errors++; $display("FAIL b2b_digest1: got %h expected %h", dig[1], ref_compress(bb, hb));
    end
    $display("back-to-back: spacing=%0d digest0=%h digest1=%h", acc_cyc[1] - acc_cyc[0], dig[0], dig[1]);
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [31:0] w0, exp_tmp2, exp_tmp3;
    logic        saw_valid;
    @(negedge clk);
    in_block = abc_blk; in_h = iv_vec; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Round 0: loaded operands and partial sums from the spec arithmetic.
    w0 = abc_blk[511:480];
    exp_tmp2 = w0 + K[0] + iv_vec[31:0];
    exp_tmp3 = exp_tmp2 + iv_vec[159:128];
    checks++;
    if (rnd_w !== abc_blk || rnd_state !== iv_vec) begin
      errors++; $display("FAIL round0_operands: got w=%h state=%h expected %h %h",
                         rnd_w, rnd_state, abc_blk, iv_vec);
    end
    checks++;
    if (rnd_k !== K[0] || rnd_t1_tmp2 !== exp_tmp2 || rnd_t1_tmp3 !== exp_tmp3) begin
      errors++; $display("FAIL round0_partials: got k=%h tmp2=%h tmp3=%h expected %h %h %h",
                         rnd_k, rnd_t1_tmp2, rnd_t1_tmp3, K[0], exp_tmp2, exp_tmp3);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (rnd_k !== K[30] || busy !== 1'b1) begin
      errors++; $display("FAIL round30_k: got k=%h busy=%b expected %h 1", rnd_k, busy, K[30]);
    end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b in_ready=%b out_valid=%b expected 0 1 0",
                         busy, in_ready, out_valid);
    end
    // abort held in IDLE with a block offered: nothing may be accepted.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_beats_valid: got busy=%b in_ready=%b expected 0 1", busy, in_ready);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++; $display("FAIL abort_no_valid: got out_valid seen=%b expected 0", saw_valid);
    end
    $display("abort at idx 30: sequencer idle");
    run_block("abc_after_abort", abc_blk, iv_vec, ABC_DIGEST);
  endtask

  task automatic test_async_reset();
    logic [511:0] b;
    logic [255:0] h;
    @(negedge clk);
    in_block = rand_block(); in_h = rand_h(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || digest !== '0) begin
      errors++;
      $display("FAIL async_reset: got in_ready=%b out_valid=%b busy=%b digest=%h expected 1 0 0 0",
               in_ready, out_valid, busy, digest);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("async reset mid-round applied");
    b = rand_block();
    h = rand_h();
    run_block("after_reset", b, h, ref_compress(b, h));
  endtask

  initial begin
    iv_vec    = {H0[0], H0[1], H0[2], H0[3], H0[4], H0[5], H0[6], H0[7]};
    abc_blk   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    empty_blk = {32'h80000000, {15{32'h0}}};
    test_reset();
    test_known_answers();
    test_random();
    test_stall();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
